// File: rtl/sdp_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sdp_pkg
//  Description : Shared widths and record types for the two-requester
//                arbitrated add/subtract pipeline (sdp_arbiter, sdp_pipe).
//                DATA_W  - operand / result width
//                NUM_REQ - number of requesters
//                op_t    - one accepted operation (controls, operands, id)
//                rsp_t   - one result record (id, data) as held in the FIFO
//  Revision    : 1.0 - initial release
// ============================================================================
package sdp_pkg;

    localparam int DATA_W  = 8;
    localparam int NUM_REQ = 2;
    localparam int ID_W    = 1;    // enough bits to name one of NUM_REQ requesters

    typedef struct packed {
        logic              ctl_1;  // stage-2 select: 0 add, 1 subtract
        logic              ctl_2;  // stage-3 select: 1 add, 0 subtract
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
        logic [DATA_W-1:0] c;
        logic [ID_W-1:0]   id;
    } op_t;

    typedef struct packed {
        logic [ID_W-1:0]   id;
        logic [DATA_W-1:0] data;
    } rsp_t;

endpackage

`default_nettype wire

// File: rtl/sdp_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : sdp_pipe
//  Description : Three-stage, valid-tagged, never-stalling datapath.
//                Stage 1 registers the accepted operation (or a bubble),
//                stage 2 registers m = ctl_1 ? a-b : a+b,
//                stage 3 registers n = ctl_2 ? m+c : m-c (all modulo 2^DATA_W).
//                Ports:
//                  clk, reset - clock, synchronous active-high reset
//                  i_valid    - an operation is accepted this cycle
//                  i_op       - the accepted operation
//                  o_valid    - stage-3 holds a result
//                  o_rsp      - stage-3 result record (id, data)
//  Revision    : 1.0 - initial release
// ============================================================================
module sdp_pipe
    import sdp_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic i_valid,
    input  op_t  i_op,
    output logic o_valid,
    output rsp_t o_rsp
);

    // Stage 1: captured operation
    logic              r_s1_valid;
    op_t               r_s1_op;

    // Stage 2: partial result plus what stage 3 still needs
    logic              r_s2_valid;
    logic [ID_W-1:0]   r_s2_id;
    logic              r_s2_ctl_2;
    logic [DATA_W-1:0] r_s2_c;
    logic [DATA_W-1:0] r_s2_m;

    // Stage 3: final result
    logic              r_s3_valid;
    rsp_t              r_s3_rsp;

    logic [DATA_W-1:0] w_m;
    logic [DATA_W-1:0] w_n;

    // Truncation to DATA_W gives the modulo-2^DATA_W arithmetic for free.
    assign w_m = r_s1_op.ctl_1 ? (r_s1_op.a - r_s1_op.b) : (r_s1_op.a + r_s1_op.b);
    assign w_n = r_s2_ctl_2    ? (r_s2_m + r_s2_c)       : (r_s2_m - r_s2_c);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_s1_valid <= 1'b0;
            r_s1_op    <= '0;
            r_s2_valid <= 1'b0;
            r_s2_id    <= '0;
            r_s2_ctl_2 <= 1'b0;
            r_s2_c     <= '0;
            r_s2_m     <= '0;
            r_s3_valid <= 1'b0;
            r_s3_rsp   <= '0;
        end else begin
            // A non-accept cycle injects a bubble; its zeroed payload is ignored downstream.
            r_s1_valid    <= i_valid;
            r_s1_op       <= i_valid ? i_op : '0;

            r_s2_valid    <= r_s1_valid;
            r_s2_id       <= r_s1_op.id;
            r_s2_ctl_2    <= r_s1_op.ctl_2;
            r_s2_c        <= r_s1_op.c;
            r_s2_m        <= w_m;

            r_s3_valid    <= r_s2_valid;
            r_s3_rsp.id   <= r_s2_id;
            r_s3_rsp.data <= w_n;
        end
    end

    assign o_valid = r_s3_valid;
    assign o_rsp   = r_s3_rsp;

endmodule

`default_nettype wire

// File: rtl/sdp_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : sdp_arbiter
//  Description : Two-requester round-robin arbiter feeding a three-stage
//                add/subtract pipeline whose results queue in a FIFO.
//                Acceptance is throttled by an occupancy counter covering
//                every accepted-but-unpopped operation, so the FIFO can
//                never overflow even though the pipeline never stalls.
//                Ports:
//                  clk, reset            - clock, synchronous active-high reset
//                  req_valid[1:0]        - per-requester operation present
//                  req_ready[1:0]        - per-requester accept (one-hot or zero)
//                  req_ctl_1/req_ctl_2   - per-requester stage-2/stage-3 selects
//                  req_a/req_b/req_c     - operands, requester i in [8i+7:8i]
//                  rsp_valid/rsp_ready   - result handshake (pop on both high)
//                  rsp_id, rsp_data      - requester index and result at FIFO head
//  Revision    : 1.0 - initial release
// ============================================================================
module sdp_arbiter
    import sdp_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ-1:0]        req_ctl_1,
    input  logic [NUM_REQ-1:0]        req_ctl_2,
    input  logic [NUM_REQ*DATA_W-1:0] req_a,
    input  logic [NUM_REQ*DATA_W-1:0] req_b,
    input  logic [NUM_REQ*DATA_W-1:0] req_c,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [ID_W-1:0]           rsp_id,
    output logic [DATA_W-1:0]         rsp_data
);

    localparam int                c_aw    = $clog2(FIFO_DEPTH);
    localparam int                c_cw    = c_aw + 1;
    localparam logic [c_cw-1:0]   c_depth = c_cw'(FIFO_DEPTH);

    // Arbitration / occupancy
    logic                 r_ptr;      // requester currently holding priority
    logic [c_cw-1:0]      r_occ;      // accepted and not yet popped
    logic [NUM_REQ-1:0]   w_grant;
    logic                 w_accept;
    logic [ID_W-1:0]      w_sel;
    op_t                  w_op;

    // Pipeline output
    logic                 w_pipe_valid;
    rsp_t                 w_pipe_rsp;

    // Result FIFO
    rsp_t                 r_mem [FIFO_DEPTH];
    logic [c_aw-1:0]      r_wr_ptr;
    logic [c_aw-1:0]      r_rd_ptr;
    logic [c_cw-1:0]      r_fcnt;
    logic                 w_pop;
    rsp_t                 w_head;

    // ------------------------------------------------------------------
    // Round-robin grant: the priority requester wins if it is asking,
    // otherwise the other one may take the slot.
    // ------------------------------------------------------------------
    always_comb begin
        w_grant = '0;
        if (!reset && (r_occ < c_depth)) begin
            if (req_valid[r_ptr]) begin
                w_grant[r_ptr] = 1'b1;
            end else if (req_valid[~r_ptr]) begin
                w_grant[~r_ptr] = 1'b1;
            end
        end
    end

    assign req_ready = w_grant;
    assign w_accept  = |w_grant;
    assign w_sel     = w_grant[1];

    always_comb begin
        w_op       = '0;
        w_op.ctl_1 = req_ctl_1[w_sel];
        w_op.ctl_2 = req_ctl_2[w_sel];
        w_op.a     = req_a[w_sel*DATA_W +: DATA_W];
        w_op.b     = req_b[w_sel*DATA_W +: DATA_W];
        w_op.c     = req_c[w_sel*DATA_W +: DATA_W];
        w_op.id    = w_sel;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ptr <= 1'b0;
        end else if (w_accept) begin
            r_ptr <= ~w_sel;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_occ <= '0;
        end else begin
            case ({w_accept, w_pop})
                2'b10:   r_occ <= r_occ + 1'b1;
                2'b01:   r_occ <= r_occ - 1'b1;
                default: r_occ <= r_occ;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------
    sdp_pipe u_pipe (
        .clk     (clk),
        .reset   (reset),
        .i_valid (w_accept),
        .i_op    (w_op),
        .o_valid (w_pipe_valid),
        .o_rsp   (w_pipe_rsp)
    );

    // ------------------------------------------------------------------
    // Result FIFO. The occupancy limit guarantees a free slot whenever a
    // result leaves stage 3, so writes are never refused. Storage itself
    // is not reset; emptiness is tracked by r_fcnt and outputs are masked.
    // ------------------------------------------------------------------
    assign w_head    = r_mem[r_rd_ptr];
    assign rsp_valid = !reset && (r_fcnt != '0);
    assign w_pop     = rsp_valid && rsp_ready;
    assign rsp_id    = rsp_valid ? w_head.id   : '0;
    assign rsp_data  = rsp_valid ? w_head.data : '0;

    always_ff @(posedge clk) begin
        if (w_pipe_valid) begin
            r_mem[r_wr_ptr] <= w_pipe_rsp;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_fcnt   <= '0;
        end else begin
            if (w_pipe_valid) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_pipe_valid, w_pop})
                2'b10:   r_fcnt <= r_fcnt + 1'b1;
                2'b01:   r_fcnt <= r_fcnt - 1'b1;
                default: r_fcnt <= r_fcnt;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_sdp_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sdp_arbiter
//  Description : Self-checking bench for sdp_arbiter. A queue-based model
//                (accept times, due times, result queue) predicts req_ready,
//                rsp_valid, rsp_id and rsp_data every cycle; table vectors and
//                directed sequences add explicit expected values.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sdp_arbiter;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [1:0]  req_ctl_1;
    logic [1:0]  req_ctl_2;
    logic [15:0] req_a;
    logic [15:0] req_b;
    logic [15:0] req_c;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [0:0]  rsp_id;
    logic [7:0]  rsp_data;

    always #5 clk = ~clk;

    sdp_arbiter #(.FIFO_DEPTH(DEPTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_ctl_1 (req_ctl_1),
        .req_ctl_2 (req_ctl_2),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_c     (req_c),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_data  (rsp_data)
    );

    int errors = 0;
    int checks = 0;

    // Reference model state
    typedef struct {
        logic       id;
        logic [7:0] data;
        int         due;     // first cycle in which the result is at the FIFO
    } ent_t;

    ent_t pend[$];           // accepted, still travelling the pipeline
    ent_t fq[$];             // visible in the result FIFO
    int   m_ptr = 0;
    int   m_occ = 0;
    int   cyc   = 0;

    // Last observed DUT outputs (sampled at the negative edge)
    logic [1:0] obs_ready;
    logic       obs_rv;
    logic       obs_id;
    logic [7:0] obs_data;

    typedef struct {
        bit         id;
        bit         c1;
        bit         c2;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] c;
        logic [7:0] expd;
    } vec_t;

    vec_t vt[6];

    function automatic logic [7:0] calc(input bit c1, input bit c2,
                                        input int a, input int b, input int c);
        int m;
        int n;
        m = c1 ? (a - b) : (a + b);
        m = ((m % 256) + 256) % 256;
        n = c2 ? (m + c) : (m - c);
        n = ((n % 256) + 256) % 256;
        return n[7:0];
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: cycle %0d got %0h expected %0h", nm, cyc, act, expv);
        end
    endtask

    task automatic set_op(input int i, input bit c1, input bit c2,
                          input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
        req_ctl_1[i]     = c1;
        req_ctl_2[i]     = c2;
        req_a[8*i +: 8]  = a;
        req_b[8*i +: 8]  = b;
        req_c[8*i +: 8]  = c;
    endtask

    // One clock cycle: predict, compare at negedge, advance the model at posedge.
    task automatic step();
        logic [1:0] exp_ready;
        logic       exp_rv;
        int         i;
        ent_t       e;
        while (pend.size() > 0 && pend[0].due <= cyc) fq.push_back(pend.pop_front());
        exp_ready = 2'b00;
        if (!reset && m_occ < DEPTH) begin
            if (req_valid[m_ptr])        exp_ready[m_ptr]   = 1'b1;
            else if (req_valid[1-m_ptr]) exp_ready[1-m_ptr] = 1'b1;
        end
        exp_rv = !reset && (fq.size() > 0);
        @(negedge clk);
        obs_ready = req_ready;
        obs_rv    = rsp_valid;
        obs_id    = rsp_id[0];
        obs_data  = rsp_data;
        chk("req_ready", req_ready, exp_ready);
        chk("rsp_valid", rsp_valid, exp_rv);
        if (exp_rv) begin
            chk("rsp_id", rsp_id, fq[0].id);
            chk("rsp_data", rsp_data, fq[0].data);
        end
        if (reset) begin
            chk("rst_rsp_id", rsp_id, 0);
            chk("rst_rsp_data", rsp_data, 0);
        end
        @(posedge clk);
        if (reset) begin
            pend.delete();
            fq.delete();
            m_ptr = 0;
            m_occ = 0;
        end else begin
            if (exp_ready != 2'b00) begin
                i      = exp_ready[1] ? 1 : 0;
                e.id   = i[0];
                e.data = calc(req_ctl_1[i], req_ctl_2[i], int'(req_a[8*i +: 8]),
                              int'(req_b[8*i +: 8]), int'(req_c[8*i +: 8]));
                e.due  = cyc + 4;
                pend.push_back(e);
                m_occ++;
                m_ptr  = 1 - i;
            end
            if (exp_rv && rsp_ready) begin
                void'(fq.pop_front());
                m_occ--;
            end
        end
        cyc++;
        #1;
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        req_valid = 2'b00;
        step();
        step();
        reset     = 1'b0;
    endtask

    task automatic drain(input int n);
        req_valid = 2'b00;
        rsp_ready = 1'b1;
        repeat (n) step();
    endtask

    initial begin
        #500000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end

    initial begin
        int lat;
        int acc;
        int acc_ids[$];
        int rsp_ids[$];
        int exp_seq[4];

        reset     = 1'b1;
        req_valid = 2'b00;
        req_ctl_1 = 2'b00;
        req_ctl_2 = 2'b00;
        req_a     = '0;
        req_b     = '0;
        req_c     = '0;
        rsp_ready = 1'b1;
        exp_seq   = '{0, 1, 0, 1};

        vt[0] = '{id:1'b0, c1:1'b0, c2:1'b1, a:8'd10,  b:8'd20,  c:8'd5,   expd:8'd35};
        vt[1] = '{id:1'b1, c1:1'b1, c2:1'b1, a:8'd3,   b:8'd5,   c:8'd4,   expd:8'd2};
        vt[2] = '{id:1'b0, c1:1'b1, c2:1'b0, a:8'd0,   b:8'd1,   c:8'd0,   expd:8'd255};
        vt[3] = '{id:1'b1, c1:1'b0, c2:1'b0, a:8'd200, b:8'd100, c:8'd50,  expd:8'd250};
        vt[4] = '{id:1'b0, c1:1'b0, c2:1'b1, a:8'd255, b:8'd255, c:8'd255, expd:8'd253};
        vt[5] = '{id:1'b1, c1:1'b1, c2:1'b0, a:8'd7,   b:8'd7,   c:8'd1,   expd:8'd255};

        @(posedge clk);
        #1;
        do_reset();
        chk("reset_ready", obs_ready, 2'b00);
        chk("reset_rsp_valid", obs_rv, 1'b0);

        // Single operations: latency 4, id and data from the table
        foreach (vt[v]) begin
            req_valid = 2'b00;
            set_op(vt[v].id, vt[v].c1, vt[v].c2, vt[v].a, vt[v].b, vt[v].c);
            req_valid[vt[v].id] = 1'b1;
            rsp_ready = 1'b1;
            step();
            chk("vec_accept", obs_ready, vt[v].id ? 2'b10 : 2'b01);
            req_valid = 2'b00;
            lat = 0;
            for (int k = 1; k <= 10; k++) begin
                step();
                if (obs_rv) begin
                    lat = k;
                    break;
                end
            end
            chk("vec_latency", lat, 4);
            chk("vec_id", obs_id, vt[v].id);
            chk("vec_data", obs_data, vt[v].expd);
        end
        drain(3);

        // Both requesters continuously valid from pointer 0: alternate 0,1,0,1
        do_reset();
        set_op(0, 1'b0, 1'b1, 8'd1, 8'd2, 8'd3);
        set_op(1, 1'b1, 1'b0, 8'd9, 8'd4, 8'd1);
        req_valid = 2'b11;
        rsp_ready = 1'b1;
        for (int k = 0; k < 12; k++) begin
            if (k == 4) req_valid = 2'b00;
            step();
            if (obs_ready != 2'b00) acc_ids.push_back(obs_ready[1] ? 1 : 0);
            if (obs_rv) rsp_ids.push_back(int'(obs_id));
        end
        chk("rr_acc_count", acc_ids.size(), 4);
        chk("rr_rsp_count", rsp_ids.size(), 4);
        for (int k = 0; k < 4; k++) begin
            if (k < acc_ids.size()) chk("rr_acc_order", acc_ids[k], exp_seq[k]);
            if (k < rsp_ids.size()) chk("rr_rsp_order", rsp_ids[k], exp_seq[k]);
        end

        // Back-pressure: four accepts fill the budget, one pop frees one slot
        do_reset();
        set_op(1, 1'b0, 1'b1, 8'd5, 8'd6, 8'd7);
        rsp_ready = 1'b0;
        req_valid = 2'b10;
        acc = 0;
        repeat (10) begin
            step();
            if (obs_ready[1]) acc++;
        end
        chk("full_accepts", acc, 4);
        chk("full_ready_low", obs_ready, 2'b00);
        rsp_ready = 1'b1;
        step();
        chk("full_pop_valid", obs_rv, 1'b1);
        chk("full_ready_indep", obs_ready, 2'b00);
        rsp_ready = 1'b0;
        step();
        chk("full_one_more", obs_ready, 2'b10);
        acc = 0;
        repeat (4) begin
            step();
            if (obs_ready[1]) acc++;
        end
        chk("full_no_extra", acc, 0);
        drain(8);

        // Reset with two operations in flight flushes everything
        do_reset();
        set_op(0, 1'b0, 1'b0, 8'd40, 8'd2, 8'd1);
        req_valid = 2'b01;
        rsp_ready = 1'b1;
        step();
        step();
        req_valid = 2'b00;
        reset = 1'b1;
        step();
        reset = 1'b0;
        for (int k = 0; k < 6; k++) begin
            step();
            chk("flush_rsp_valid", obs_rv, 1'b0);
        end
        rsp_ready = 1'b0;
        req_valid = 2'b01;
        acc = 0;
        repeat (6) begin
            step();
            if (obs_ready[0]) acc++;
        end
        chk("flush_occ_zero", acc, 4);
        drain(8);

        // Only requester 1 asking right after reset: accepted immediately
        do_reset();
        set_op(1, 1'b1, 1'b1, 8'd8, 8'd3, 8'd2);
        req_valid = 2'b10;
        step();
        chk("r1_after_reset", obs_ready, 2'b10);
        drain(6);

        // Randomized traffic: light back-pressure, then heavy, with rare resets
        for (int k = 0; k < 600; k++) begin
            req_valid = 2'($urandom);
            req_ctl_1 = 2'($urandom);
            req_ctl_2 = 2'($urandom);
            req_a     = 16'($urandom);
            req_b     = 16'($urandom);
            req_c     = 16'($urandom);
            rsp_ready = (k < 300) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
            reset     = ($urandom_range(0, 79) == 0);
            step();
        end
        reset = 1'b0;
        drain(10);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/sdp_arbiter.md
SDP_ARBITER -- requirements
Module: sdp_arbiter

Interface
REQ-001 Parameter: FIFO_DEPTH, 4, result-FIFO entries and maximum accepted-but-unpopped operations (power of 2, >=4).
REQ-002 clk  input  1  clock; all state on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 req_valid  input  2  bit i: requester i presents an operation.
REQ-005 req_ready  output  2  bit i: requester i's operation is accepted this cycle.
REQ-006 req_ctl_1  input  2  bit i: stage-2 select for requester i (0 add, 1 subtract).
REQ-007 req_ctl_2  input  2  bit i: stage-3 select for requester i (1 add, 0 subtract).
REQ-008 req_a  input  16  operand a; requester i in bits [8i+7:8i].
REQ-009 req_b  input  16  operand b; same packing.
REQ-010 req_c  input  16  operand c; same packing.
REQ-011 rsp_valid  output  1  FIFO head holds a result.
REQ-012 rsp_ready  input  1  consumer pops the head when rsp_valid is also high.
REQ-013 rsp_id  output  1  requester index of the head result.
REQ-014 rsp_data  output  8  head result.

Function
REQ-015 Accept: req_valid[i] & req_ready[i] at a rising edge; at most one req_ready bit high per cycle.
REQ-016 req_ready[i] high iff req_valid[i], occupancy < FIFO_DEPTH, reset low, and i wins arbitration; req_ready is independent of rsp_ready.
REQ-017 Arbitration is round-robin: pointer names the priority requester; on accepting from i, the pointer moves to 1-i; with no accept, the pointer holds.
REQ-018 Occupancy counter: +1 on accept, -1 on pop, unchanged when both or neither occur; range 0..FIFO_DEPTH.
REQ-019 Pipeline stage 1 captures ctl_1, ctl_2, a, b, c, id and valid=1 on accept; otherwise it loads valid=0 (bubble).
REQ-020 Stage 2: m = ctl_1 ? a-b : a+b; stage 3: n = ctl_2 ? m+c : m-c; all arithmetic is modulo 256.
REQ-021 The pipeline never stalls; valid and id travel with the data through all three stages.
REQ-022 A valid stage-3 result is written to the FIFO at the next edge; for an accept in cycle 0 into an empty FIFO, rsp_valid is first high in cycle 4.
REQ-023 Results leave the FIFO in acceptance order; rsp_data and rsp_id are stable while rsp_valid is high and rsp_ready is low.
REQ-024 FIFO overflow is impossible by REQ-016 and REQ-018; a simultaneous FIFO write and pop is allowed at any occupancy.
REQ-025 Bubbles do not write the FIFO.

Reset
REQ-026 While reset is high: req_ready=0, rsp_valid=0, rsp_id=0, rsp_data=0, pointer=0, occupancy=0, FIFO empty, all pipeline valid bits and data = 0.
REQ-027 Reset mid-operation discards every in-flight and queued result; none is ever presented on rsp_*.
REQ-028 In the first cycle after reset deasserts, requester 0 has priority.

Structure
REQ-029 Package sdp_pkg holds DATA_W=8, NUM_REQ=2, and the op typedef (ctl_1, ctl_2, a, b, c, id).
REQ-030 The three-stage valid-tagged datapath is one sub-module, sdp_pipe; arbiter, counter and FIFO reside in sdp_arbiter.

Verification
REQ-031 Single op: r0 ctl_1=0, ctl_2=1, a=10, b=20, c=5 accepted in cycle 0, rsp_ready=1 -> rsp_valid in cycle 4, rsp_id=0, rsp_data=35.
REQ-032 Both requesters valid continuously, pointer=0 -> accepts in order 0,1,0,1; rsp_id sequence is 0,1,0,1.
REQ-033 Wrap-around: ctl_1=1, a=3, b=5, ctl_2=1, c=4 -> rsp_data=2 (m=254).
REQ-034 rsp_ready=0, r1 valid continuously -> exactly 4 accepts, then req_ready=0; one pop -> exactly one further accept, in the next cycle.
REQ-035 Two ops in flight, then reset high for 1 cycle -> rsp_valid stays 0 for 6 cycles with no new requests, and occupancy=0.
REQ-036 Only r1 valid after reset -> r1 is accepted immediately despite pointer=0.
